// File: rtl/decoder_csc_pipe.sv
// Two-stage colour-space conversion pipeline: S1 converts YCoCg to RGB (or passes
// through), S2 clips every sample to [0, maxPoint] and drives the output handshake.
module decoder_csc_pipe #(
    parameter int MAX_SLICE_WIDTH = 2560,
    parameter int BLK_W           = 8,
    parameter int BLK_H           = 2,
    parameter int IN_W            = 14,
    parameter int OUT_W           = 12
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic [1:0]                           csc,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]   slice_width,
    input  logic [OUT_W-1:0]                     maxPoint,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [3*BLK_H*BLK_W*IN_W-1:0]        in_blk_p,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [3*BLK_H*BLK_W*OUT_W-1:0]       out_blk_p,
    output logic                                 out_eol
);

    localparam int NPIX  = BLK_H * BLK_W;
    localparam int CW    = IN_W + 2;
    localparam int SW_W  = $clog2(MAX_SLICE_WIDTH);
    localparam int CNT_W = SW_W + 1;

    function automatic logic [OUT_W-1:0] sat(input logic signed [CW-1:0] v,
                                             input logic [OUT_W-1:0] mx);
        logic signed [CW-1:0] lim;
        lim = $signed(CW'(mx));
        if (v[CW-1])
            return '0;
        else if (v > lim)
            return mx;
        else
            return v[OUT_W-1:0];
    endfunction

    logic                      r_vld_p1;
    logic                      r_vld_p2;
    logic [CNT_W-1:0]          r_blk_cnt;
    logic [3*NPIX*CW-1:0]      r_dat_p1;
    logic [3*NPIX*OUT_W-1:0]   r_dat_p2;

    logic                      w_ld_p1;
    logic                      w_ld_p2;
    logic                      w_acc;
    logic                      w_xfer;
    logic                      w_ycocg;
    logic [CNT_W-1:0]          w_bpl;
    logic                      w_eol_hit;
    logic [3*NPIX*CW-1:0]      w_cv;

    assign w_ld_p2  = ~r_vld_p2 | out_ready;
    assign w_ld_p1  = ~r_vld_p1 | w_ld_p2;
    assign in_ready = ~flush & w_ld_p1;
    assign w_acc    = in_valid & in_ready;
    assign w_xfer   = r_vld_p2 & out_ready & ~flush;
    assign w_ycocg  = (csc == 2'd1);

    // Blocks per line rounds up so a partial trailing block still ends the line.
    assign w_bpl     = CNT_W'((32'(slice_width) + 32'(BLK_W - 1)) / 32'(BLK_W));
    assign w_eol_hit = (r_blk_cnt == w_bpl - CNT_W'(1));

    assign out_valid = r_vld_p2;
    assign out_eol   = r_vld_p2 & w_eol_hit;
    assign out_blk_p = r_dat_p2;

    for (genvar p = 0; p < NPIX; p++) begin : g_px
        logic signed [CW-1:0] w_y, w_co, w_cg, w_t, w_g, w_b, w_r;
        assign w_y  = CW'($signed(in_blk_p[(0*NPIX+p)*IN_W +: IN_W]));
        assign w_co = CW'($signed(in_blk_p[(1*NPIX+p)*IN_W +: IN_W]));
        assign w_cg = CW'($signed(in_blk_p[(2*NPIX+p)*IN_W +: IN_W]));
        assign w_t  = w_y - (w_cg >>> 1);
        assign w_g  = w_cg + w_t;
        assign w_b  = w_t - (w_co >>> 1);
        assign w_r  = w_b + w_co;
        assign w_cv[(0*NPIX+p)*CW +: CW] = w_ycocg ? w_r : w_y;
        assign w_cv[(1*NPIX+p)*CW +: CW] = w_ycocg ? w_g : w_co;
        assign w_cv[(2*NPIX+p)*CW +: CW] = w_ycocg ? w_b : w_cg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_blk_cnt <= '0;
        end else if (flush) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_blk_cnt <= '0;
        end else begin
            if (w_ld_p2)
                r_vld_p2 <= r_vld_p1;
            if (w_ld_p1)
                r_vld_p1 <= w_acc;
            if (w_xfer)
                r_blk_cnt <= w_eol_hit ? '0 : r_blk_cnt + CNT_W'(1);
        end
    end

    // S1: converted samples; the mode is baked in here so it travels with the block
    always_ff @(posedge clk) begin
        if (w_acc)
            r_dat_p1 <= w_cv;
    end

    // S2: clipped output samples
    always_ff @(posedge clk) begin
        if (w_ld_p2 && r_vld_p1) begin
            for (int k = 0; k < 3*NPIX; k++)
                r_dat_p2[k*OUT_W +: OUT_W] <= sat(r_dat_p1[k*CW +: CW], maxPoint);
        end
    end

endmodule

// File: doc/decoder_csc_pipe.md
DECODER_CSC_PIPE -- requirements
Module: decoder_csc_pipe

Interface
REQ-001: Parameter MAX_SLICE_WIDTH, default 2560, is the maximum slice width in pixels.
REQ-002: Parameter BLK_W, default 8, is the number of pixel columns per block.
REQ-003: Parameter BLK_H, default 2, is the number of pixel rows per block.
REQ-004: Parameter IN_W, default 14, is the signed width of each input sample.
REQ-005: Parameter OUT_W, default 12, is the unsigned width of each output sample.
REQ-006: clk  in  1  clock; all logic rises on posedge clk.
REQ-007: rst_n  in  1  reset, asynchronous, active-low.
REQ-008: flush  in  1  synchronous pipeline clear.
REQ-009: csc  in  2  colour mode: 0 RGB, 1 YCoCg, 2 YCbCr, 3 reserved (same as 0). The block samples csc when it accepts each input block.
REQ-010: slice_width  in  $clog2(MAX_SLICE_WIDTH)  slice width in pixels; held static between flushes.
REQ-011: maxPoint  in  OUT_W  clip ceiling; held static between flushes.
REQ-012: in_valid, in_ready  in/out  1 each  input handshake.
REQ-013: in_blk_p  in  3*BLK_H*BLK_W*IN_W  input block, component-major, then row, then column: sample index (cp*BLK_H*BLK_W + r*BLK_W + c)*IN_W.
REQ-014: out_valid, out_ready  out/in  1 each  output handshake.
REQ-015: out_blk_p  out  3*BLK_H*BLK_W*OUT_W  converted block, packed in the same order with OUT_W per sample.
REQ-016: out_eol  out  1  marks the last block of a slice line; valid only while out_valid is high.

Function
REQ-017: An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-018: The pipeline has 2 register stages: S1 does conversion, S2 does clipping and drives the outputs.
- Latency is 2 cycles from accept to out_valid when there is no backpressure.
- Throughput is 1 block per cycle.
REQ-019: S2 loads when it is empty or its block is being transferred out; S1 loads when it is empty or S2 loads.
- in_ready = ~s1_valid | ~s2_valid | out_ready.
- in_ready is combinational.
REQ-020: While out_valid && ~out_ready, out_blk_p and out_eol hold stable and no accepted block is dropped or duplicated.
REQ-021: Mode 1 conversion, per pixel, in IN_W+2-bit signed arithmetic with arithmetic shifts, where Y, Co, Cg are components 0, 1, 2:
- t = Y - (Cg>>>1)
- G = Cg + t
- B = t - (Co>>>1)
- R = B + Co
- Output components are 0=R, 1=G, 2=B.
REQ-022: Modes 0, 2 and 3 pass each component through unchanged.
REQ-023: Every output sample is clipped to [0, maxPoint]: negative values give 0, and values above maxPoint give maxPoint.
REQ-024: The mode travels with its block, so a csc change takes effect only on blocks accepted afterwards.
REQ-025: blk_cnt counts output transfers; blocks per line = ceil(slice_width/BLK_W).
- out_eol = (blk_cnt == blocks_per_line-1).
- On the eol transfer, blk_cnt wraps to 0.
REQ-026: flush clears s1_valid, s2_valid and blk_cnt on the next edge.
- Any in-flight block is discarded.
- An input presented in the flush cycle is not accepted: in_ready is forced to 0 while flush is high.
REQ-027: If flush and out_ready are high together, no output transfer is counted and blk_cnt is 0 afterwards.

Reset
REQ-028: While rst_n is low: out_valid=0, out_eol=0, s1_valid=0, s2_valid=0, blk_cnt=0, and in_ready=1 once flush is low.
REQ-029: Data registers are not reset; out_blk_p is don't-care while out_valid=0.
REQ-030: Assertion of rst_n mid-operation discards all in-flight blocks; the first block accepted after release appears with blk_cnt=0.

Verification
REQ-031: Mode 1, maxPoint=4095, Y=2048, Co=0, Cg=0 -> all outputs R=G=B=2048, out_valid 2 cycles after accept.
REQ-032: Mode 1, Y=100, Co=-400, Cg=0 -> R=0 (clipped from -100), G=100, B=300.
- Mode 0, input 5000 with maxPoint=1023 -> output 1023.
REQ-033: slice_width=20, BLK_W=8, 6 back-to-back blocks with out_ready=1 -> out_eol on blocks 3 and 6.
REQ-034: Stream 10 blocks with out_ready toggled pseudo-randomly -> all 10 outputs in order, no drops or duplicates, data stable while stalled, and in_ready=0 only when both stages are full and out_ready=0.
REQ-035: Flush asserted with both stages full and out_ready=1 -> next cycle out_valid=0 and blk_cnt=0, and the next block accepted has out_eol computed from count 0.
REQ-036: csc switched from 1 to 0 between two back-to-back blocks -> the first block is converted and the second is passed through.
